// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush control for the five-stage core: stall vector, wrong-path kill and PC redirect.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_stall_req_i,
    input  logic              id_stall_req_i,
    input  logic              mem_stall_req_i,
    input  logic              ex_branch_i,
    input  logic [ADDR_W-1:0] ex_target_i,
    output logic [4:0]        stall_o,
    output logic              branch_interception_o,
    output logic              redirect_valid_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic              busy_pend_o,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       flush_cnt_o
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StPend  = 2'd1,
        StFlush = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0] redir_addr_q, redir_addr_d;
    logic              redir_valid_q, redir_valid_d;
    logic              acc;
    logic              kill;

    // rst_in gating keeps kill/accept quiet while the core is held in reset.
    always_comb begin
        acc = 1'b0;
        if (rst_in && rdy_in && !mem_stall_req_i) begin
            acc = ((state_q == StRun) && ex_branch_i) || (state_q == StPend);
        end
    end

    assign kill = acc || (state_q == StFlush);

    always_comb begin
        stall_o = 5'b00000;
        if (!rst_in || !rdy_in) begin
            stall_o = 5'b11111;
        end else if (mem_stall_req_i) begin
            stall_o = 5'b01111;
        end else if (acc) begin
            stall_o = 5'b00000;
        end else if (id_stall_req_i && !kill) begin
            stall_o = 5'b00011;
        end else if (if_stall_req_i) begin
            stall_o = 5'b00001;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_addr_d   = pend_addr_q;
        redir_addr_d  = redir_addr_q;
        redir_valid_d = acc;
        unique case (state_q)
            StRun: begin
                if (rdy_in && ex_branch_i) begin
                    if (mem_stall_req_i) begin
                        pend_addr_d = ex_target_i;
                        state_d     = StPend;
                    end else begin
                        redir_addr_d = ex_target_i;
                        state_d      = StFlush;
                    end
                end
            end
            StPend: begin
                if (acc) begin
                    redir_addr_d = pend_addr_q;
                    state_d      = StFlush;
                end
            end
            StFlush: begin
                if (rdy_in) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= StRun;
            pend_addr_q   <= '0;
            redir_addr_q  <= '0;
            redir_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_addr_q   <= pend_addr_d;
            redir_addr_q  <= redir_addr_d;
            redir_valid_q <= redir_valid_d;
        end
    end

    assign branch_interception_o = kill;
    assign redirect_valid_o      = redir_valid_q;
    assign redirect_addr_o       = redir_addr_q;
    assign busy_pend_o           = (state_q == StPend);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cnt_d    = flush_cnt_q;
        if (stall_o[0] && rdy_in) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (redir_valid_q) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cycles_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_cnt_o    = flush_cnt_q;
`else
    assign stall_cycles_o = '0;
    assign flush_cnt_o    = '0;
`endif

    // Redirect strobe lasts exactly one cycle and is always followed by the FLUSH kill.
    a_redir_pulse : assert property (@(posedge clk_in) disable iff (!rst_in)
        redir_valid_q |=> !redir_valid_q);
    a_redir_in_flush : assert property (@(posedge clk_in) disable iff (!rst_in)
        redir_valid_q |-> (state_q == StFlush));

endmodule
